mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255: max cycles a granted memory access may wait for mem_ack before abort.
REQ-002 Parameter AW, default 32: address width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; block reset when sampled 0 at rising clk.
REQ-005 if_req  input  1  instruction-fetch request, held until if_ack.
REQ-006 if_addr  input  AW  fetch address (PC).
REQ-007 if_ack  output  1  one-cycle pulse: fetch complete, if_rdata valid.
REQ-008 if_rdata  output  32  fetched instruction.
REQ-009 d_req  input  1  data request from load/store, held until d_ack.
REQ-010 d_we  input  1  1 = store, 0 = load.
REQ-011 d_addr  input  AW  data address (ALUResult).
REQ-012 d_wdata  input  32  store data (WriteData).
REQ-013 d_be  input  4  byte enables for store.
REQ-014 d_ack  output  1  one-cycle pulse: data access complete, d_rdata valid on loads.
REQ-015 d_rdata  output  32  load data (ReadData).
REQ-016 mem_req, mem_we, mem_addr[AW], mem_wdata[32], mem_be[4]  outputs  request to single-ported memory.
REQ-017 mem_ack  input  1  memory completion pulse; mem_rdata valid same cycle.
REQ-018 mem_rdata  input  32  memory read data.
REQ-019 stall  output  1  high while any requester is waiting (req high, ack not yet given); freezes PC register upstream.
REQ-020 err  output  1  sticky timeout flag.

Function
REQ-021 States: IDLE, GNT_I, GNT_D, ABORT; encoding free.
REQ-022 IDLE: d_req=1 -> GNT_D; else if_req=1 -> GNT_I; else stay. Data has fixed priority over fetch.
REQ-023 On entering GNT_x, mem_addr/mem_we/mem_wdata/mem_be latched from the winning requester; mem_req=1 every cycle in GNT_x.
REQ-024 mem_we=1 only in GNT_D with latched d_we=1; mem_be=4'b0000 in GNT_I and on loads.
REQ-025 GNT_x with mem_ack=1: x_ack=1 same cycle, x_rdata=mem_rdata registered-through (valid that cycle), next state IDLE; minimum access latency 2 cycles req-to-ack (grant cycle + ack cycle).
REQ-026 if_rdata/d_rdata hold last captured value between acks.
REQ-027 Wait counter cleared on grant, +1 per GNT_x cycle without mem_ack; reaching TIMEOUT -> ABORT.
REQ-028 ABORT (one cycle): mem_req=0, err set, x_ack=1 for the aborted requester with x_rdata=32'h0000_0013 (NOP) for fetch, 32'h0 for data; next IDLE.
REQ-029 mem_ack in IDLE or ABORT ignored; no ack pulse generated.
REQ-030 Requester dropping req while granted: access still completes; ack pulse still issued.
REQ-031 d_req and if_req rising same cycle in IDLE: data served first, fetch granted in IDLE following d_ack (no starvation: fetch served at most one access later).
REQ-032 stall = (if_req & ~if_ack) | (d_req & ~d_ack), combinational.
REQ-033 err clears only on reset.

Reset
REQ-034 reset=0 at rising clk: state IDLE, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, if_ack=0, d_ack=0, if_rdata=0, d_rdata=0, err=0, counter=0.
REQ-035 Reset mid-access abandons the transaction; no ack pulse issued; mem_req=0 the cycle after reset sampled.

Verification
REQ-036 if_req=1, if_addr=0x100, mem_ack 1 cycle after grant with mem_rdata=0x00500093 -> if_ack pulse, if_rdata=0x00500093, mem_we=0.
REQ-037 if_req and d_req (store, d_addr=0x2000, d_wdata=0xDEADBEEF, d_be=4'hF) same cycle -> store granted first with mem_we=1, then fetch; one ack each, stall low after last ack.
REQ-038 load d_addr=0x40, mem_ack after 5 wait cycles, mem_rdata=0x12345678 -> d_ack single pulse, d_rdata=0x12345678, stall high 6 cycles.
REQ-039 TIMEOUT=8, fetch granted, mem_ack never -> ABORT after 8 wait cycles, if_ack with if_rdata=0x00000013, err=1 until reset.
REQ-040 reset=0 asserted in GNT_D -> next cycle state IDLE, all outputs per REQ-034, no d_ack.
REQ-041 spurious mem_ack in IDLE -> no if_ack/d_ack, state unchanged.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between an instruction-fetch port and a load/store port.
// Data wins ties; a granted access with no mem_ack_i for TIMEOUT cycles is aborted.
//   state | meaning
//   IDLE  | nothing in flight, arbitrating between requesters
//   GNT_I | fetch access presented to memory
//   GNT_D | load/store access presented to memory
//   ABORT | timed-out access acked with a dummy result
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned AW      = 32
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          if_req_i,
    input  logic [AW-1:0] if_addr_i,
    output logic          if_ack_o,
    output logic [31:0]   if_rdata_o,
    input  logic          d_req_i,
    input  logic          d_we_i,
    input  logic [AW-1:0] d_addr_i,
    input  logic [31:0]   d_wdata_i,
    input  logic [3:0]    d_be_i,
    output logic          d_ack_o,
    output logic [31:0]   d_rdata_o,
    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [31:0]   mem_wdata_o,
    output logic [3:0]    mem_be_o,
    input  logic          mem_ack_i,
    input  logic [31:0]   mem_rdata_i,
    output logic          stall_o,
    output logic          err_o
);

    localparam int unsigned   CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [31:0]   NOP_INSN = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, ABORT} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          abort_d_q;
    logic          err_q;
    logic          mem_req_q;
    logic          mem_we_q;
    logic [AW-1:0] mem_addr_q;
    logic [31:0]   mem_wdata_q;
    logic [3:0]    mem_be_q;
    logic [31:0]   if_rdata_q;
    logic [31:0]   d_rdata_q;
    logic [31:0]   if_rdata_d;
    logic [31:0]   d_rdata_d;
    logic          if_ack;
    logic          d_ack;

    // Acks follow mem_ack_i in the same cycle, so read data is passed straight through.
    always_comb begin
        if_ack     = 1'b0;
        d_ack      = 1'b0;
        if_rdata_d = mem_rdata_i;
        d_rdata_d  = mem_rdata_i;
        case (state_q)
            GNT_I: if_ack = mem_ack_i;
            GNT_D: d_ack  = mem_ack_i;
            ABORT: begin
                if_ack     = ~abort_d_q;
                d_ack      = abort_d_q;
                if_rdata_d = NOP_INSN;
                d_rdata_d  = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            abort_d_q   <= 1'b0;
            err_q       <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            if (if_ack) begin
                if_rdata_q <= if_rdata_d;
            end
            if (d_ack) begin
                d_rdata_q <= d_rdata_d;
            end
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (d_req_i) begin
                        state_q     <= GNT_D;
                        abort_d_q   <= 1'b1;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= d_we_i;
                        mem_addr_q  <= d_addr_i;
                        mem_wdata_q <= d_wdata_i;
                        mem_be_q    <= d_we_i ? d_be_i : 4'b0000;
                    end else if (if_req_i) begin
                        state_q     <= GNT_I;
                        abort_d_q   <= 1'b0;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= if_addr_i;
                        mem_wdata_q <= '0;
                        mem_be_q    <= 4'b0000;
                    end
                end
                GNT_I, GNT_D: begin
                    if (mem_ack_i) begin
                        state_q   <= IDLE;
                        cnt_q     <= '0;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        mem_be_q  <= 4'b0000;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q   <= ABORT;
                        cnt_q     <= cnt_q + CW'(1);
                        err_q     <= 1'b1;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        mem_be_q  <= 4'b0000;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ABORT: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign if_ack_o    = if_ack;
    assign d_ack_o     = d_ack;
    assign if_rdata_o  = if_ack ? if_rdata_d : if_rdata_q;
    assign d_rdata_o   = d_ack ? d_rdata_d : d_rdata_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_be_o    = mem_be_q;
    assign err_o       = err_q;
    assign stall_o     = (if_req_i & ~if_ack) | (d_req_i & ~d_ack);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized transactions
// checked against a cycle-schedule model derived from the arbitration rules.
module tb_mem_port_arbiter;

    localparam int          TO  = 8;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_ack_o;
    logic [31:0] if_rdata_o;
    logic        d_req_i;
    logic        d_we_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_wdata_i;
    logic [3:0]  d_be_i;
    logic        d_ack_o;
    logic [31:0] d_rdata_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        stall_o;
    logic        err_o;

    int passed = 0;
    int total  = 0;

    mem_port_arbiter #(.TIMEOUT(TO), .AW(32)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_ack_o(if_ack_o), .if_rdata_o(if_rdata_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
        .d_be_i(d_be_i), .d_ack_o(d_ack_o), .d_rdata_o(d_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
        .stall_o(stall_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic inputs_idle();
        if_req_i = 0; if_addr_i = 0; d_req_i = 0; d_we_i = 0; d_addr_i = 0;
        d_wdata_i = 0; d_be_i = 0; mem_ack_i = 0; mem_rdata_i = 0;
    endtask

    // Leaves the bench just after a rising edge with reset released, ready to drive cycle 0.
    task automatic do_reset();
        inputs_idle();
        reset_i = 0;
        @(posedge clk_i); #1;
        reset_i = 1;
    endtask

    task automatic next_cycle();
        @(posedge clk_i); #1;
    endtask

    task automatic test_reset();
        inputs_idle();
        reset_i = 0;
        mem_ack_i = 1; mem_rdata_i = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk_i);
        #1 mem_ack_i = 0;
        @(negedge clk_i);
        total++;
        if ({mem_req_o, mem_we_o, if_ack_o, d_ack_o, err_o, stall_o} !== 6'b0)
            $display("FAIL reset_ctrl got req=%b we=%b iack=%b dack=%b err=%b stall=%b want all 0",
                     mem_req_o, mem_we_o, if_ack_o, d_ack_o, err_o, stall_o);
        else passed++;
        total++;
        if (mem_addr_o !== 32'h0 || mem_wdata_o !== 32'h0 || mem_be_o !== 4'h0)
            $display("FAIL reset_mem got addr=%h wdata=%h be=%h want 0", mem_addr_o, mem_wdata_o, mem_be_o);
        else passed++;
        total++;
        if (if_rdata_o !== 32'h0 || d_rdata_o !== 32'h0)
            $display("FAIL reset_rdata got if=%h d=%h want 0", if_rdata_o, d_rdata_o);
        else passed++;
        @(posedge clk_i); #1;
        reset_i = 1;
    endtask

    task automatic test_fetch();
        do_reset();
        if_req_i = 1; if_addr_i = 32'h100;
        @(negedge clk_i);
        total++;
        if (stall_o !== 1'b1 || mem_req_o !== 1'b0)
            $display("FAIL fetch_c0 got stall=%b req=%b want 1 0", stall_o, mem_req_o);
        else passed++;
        next_cycle();
        @(negedge clk_i);
        total++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h100 || mem_we_o !== 1'b0 || mem_be_o !== 4'h0)
            $display("FAIL fetch_grant got req=%b addr=%h we=%b be=%h want 1 100 0 0",
                     mem_req_o, mem_addr_o, mem_we_o, mem_be_o);
        else passed++;
        next_cycle();
        mem_ack_i = 1; mem_rdata_i = 32'h0050_0093;
        @(negedge clk_i);
        total++;
        if (if_ack_o !== 1'b1 || if_rdata_o !== 32'h0050_0093 || stall_o !== 1'b0 || mem_we_o !== 1'b0)
            $display("FAIL fetch_ack got ack=%b rdata=%h stall=%b we=%b want 1 00500093 0 0",
                     if_ack_o, if_rdata_o, stall_o, mem_we_o);
        else passed++;
        next_cycle();
        mem_ack_i = 0; mem_rdata_i = 32'hBAD0_BAD0; if_req_i = 0;
        @(negedge clk_i);
        total++;
        if (if_ack_o !== 1'b0 || if_rdata_o !== 32'h0050_0093 || mem_req_o !== 1'b0)
            $display("FAIL fetch_hold got ack=%b rdata=%h req=%b want 0 00500093 0",
                     if_ack_o, if_rdata_o, mem_req_o);
        else passed++;
    endtask

    task automatic test_priority();
        do_reset();
        if_req_i = 1; if_addr_i = 32'h300;
        d_req_i = 1; d_we_i = 1; d_addr_i = 32'h2000; d_wdata_i = 32'hDEAD_BEEF; d_be_i = 4'hF;
        @(negedge clk_i);
        next_cycle();
        mem_ack_i = 1; mem_rdata_i = 32'h1111_2222;
        @(negedge clk_i);
        total++;
        if (mem_req_o !== 1'b1 || mem_we_o !== 1'b1 || mem_addr_o !== 32'h2000 ||
            mem_wdata_o !== 32'hDEAD_BEEF || mem_be_o !== 4'hF)
            $display("FAIL prio_store got req=%b we=%b addr=%h wdata=%h be=%h want 1 1 2000 deadbeef f",
                     mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o);
        else passed++;
        total++;
        if (d_ack_o !== 1'b1 || if_ack_o !== 1'b0 || stall_o !== 1'b1)
            $display("FAIL prio_dack got dack=%b iack=%b stall=%b want 1 0 1", d_ack_o, if_ack_o, stall_o);
        else passed++;
        next_cycle();
        d_req_i = 0; mem_ack_i = 0;
        @(negedge clk_i);
        total++;
        if (mem_req_o !== 1'b0 || d_ack_o !== 1'b0 || if_ack_o !== 1'b0 || stall_o !== 1'b1)
            $display("FAIL prio_gap got req=%b dack=%b iack=%b stall=%b want 0 0 0 1",
                     mem_req_o, d_ack_o, if_ack_o, stall_o);
        else passed++;
        next_cycle();
        mem_ack_i = 1; mem_rdata_i = 32'h0000_0033;
        @(negedge clk_i);
        total++;
        if (mem_req_o !== 1'b1 || mem_we_o !== 1'b0 || mem_addr_o !== 32'h300 || mem_be_o !== 4'h0 ||
            if_ack_o !== 1'b1 || d_ack_o !== 1'b0)
            $display("FAIL prio_fetch got req=%b we=%b addr=%h be=%h iack=%b dack=%b want 1 0 300 0 1 0",
                     mem_req_o, mem_we_o, mem_addr_o, mem_be_o, if_ack_o, d_ack_o);
        else passed++;
        next_cycle();
        if_req_i = 0; mem_ack_i = 0;
        @(negedge clk_i);
        total++;
        if (stall_o !== 1'b0 || if_ack_o !== 1'b0 || d_ack_o !== 1'b0 || mem_req_o !== 1'b0)
            $display("FAIL prio_end got stall=%b iack=%b dack=%b req=%b want 0 0 0 0",
                     stall_o, if_ack_o, d_ack_o, mem_req_o);
        else passed++;
    endtask

    task automatic test_load_wait();
        int stall_cnt = 0;
        int ack_cnt = 0;
        int ack_cyc = -1;
        logic [31:0] rd_at_ack = 0;
        bit bad_mem = 0;
        bit done = 0;
        do_reset();
        d_we_i = 0; d_addr_i = 32'h40; d_wdata_i = $urandom; d_be_i = 4'($urandom);
        for (int c = 0; c < 10; c++) begin
            if (c > 0) next_cycle();
            d_req_i = !done;
            mem_ack_i = (c == 6);
            mem_rdata_i = (c == 6) ? 32'h1234_5678 : $urandom;
            @(negedge clk_i);
            if (stall_o) stall_cnt++;
            if (d_ack_o) begin
                ack_cnt++; ack_cyc = c; rd_at_ack = d_rdata_o; done = 1;
            end
            if (mem_req_o && (mem_addr_o !== 32'h40 || mem_be_o !== 4'h0 || mem_we_o !== 1'b0)) bad_mem = 1;
        end
        total++;
        if (stall_cnt != 6) $display("FAIL load_stall got %0d cycles want 6", stall_cnt);
        else passed++;
        total++;
        if (ack_cnt != 1 || ack_cyc != 6)
            $display("FAIL load_ack got count=%0d cycle=%0d want 1 6", ack_cnt, ack_cyc);
        else passed++;
        total++;
        if (rd_at_ack !== 32'h1234_5678 || d_rdata_o !== 32'h1234_5678)
            $display("FAIL load_rdata got ack=%h hold=%h want 12345678", rd_at_ack, d_rdata_o);
        else passed++;
        total++;
        if (bad_mem) $display("FAIL load_mem got bad addr/we/be while granted want 40 0 0");
        else passed++;
    endtask

    task automatic test_timeout();
        int ack_cnt = 0;
        int ack_cyc = -1;
        int req_cnt = 0;
        logic [31:0] rd_at_ack = 0;
        bit done = 0;
        do_reset();
        if_addr_i = 32'h500;
        for (int c = 0; c < 16; c++) begin
            if (c > 0) next_cycle();
            if_req_i = !done;
            mem_ack_i = 0; mem_rdata_i = $urandom;
            @(negedge clk_i);
            if (mem_req_o) req_cnt++;
            if (if_ack_o) begin
                ack_cnt++; ack_cyc = c; rd_at_ack = if_rdata_o; done = 1;
            end
        end
        total++;
        if (ack_cnt != 1 || ack_cyc != TO + 1)
            $display("FAIL timeout_ack got count=%0d cycle=%0d want 1 %0d", ack_cnt, ack_cyc, TO + 1);
        else passed++;
        total++;
        if (rd_at_ack !== NOP || d_ack_o !== 1'b0)
            $display("FAIL timeout_nop got rdata=%h dack=%b want 00000013 0", rd_at_ack, d_ack_o);
        else passed++;
        total++;
        if (req_cnt != TO) $display("FAIL timeout_reqcycles got %0d want %0d", req_cnt, TO);
        else passed++;
        total++;
        if (err_o !== 1'b1) $display("FAIL timeout_err_sticky got %b want 1", err_o);
        else passed++;
        do_reset();
        @(negedge clk_i);
        total++;
        if (err_o !== 1'b0) $display("FAIL timeout_err_clear got %b want 0", err_o);
        else passed++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        d_req_i = 1; d_we_i = 0; d_addr_i = 32'h44;
        @(negedge clk_i);
        next_cycle();
        mem_ack_i = 1; mem_rdata_i = 32'hCAFE_F00D;
        @(negedge clk_i);
        next_cycle();
        mem_ack_i = 0; d_req_i = 0;
        @(negedge clk_i);
        next_cycle();
        d_req_i = 1; d_we_i = 1; d_addr_i = 32'h2000; d_wdata_i = 32'h5A5A_A5A5; d_be_i = 4'h3;
        @(negedge clk_i);
        next_cycle();
        @(negedge clk_i);
        total++;
        if (mem_req_o !== 1'b1 || mem_we_o !== 1'b1 || d_rdata_o !== 32'hCAFE_F00D)
            $display("FAIL rstmid_pre got req=%b we=%b drdata=%h want 1 1 cafef00d", mem_req_o, mem_we_o, d_rdata_o);
        else passed++;
        next_cycle();
        reset_i = 0;
        @(negedge clk_i);
        total++;
        if (d_ack_o !== 1'b0) $display("FAIL rstmid_noack0 got %b want 0", d_ack_o);
        else passed++;
        next_cycle();
        reset_i = 1; d_req_i = 0;
        @(negedge clk_i);
        total++;
        if ({mem_req_o, mem_we_o, d_ack_o, if_ack_o, err_o} !== 5'b0 || mem_be_o !== 4'h0 ||
            mem_addr_o !== 32'h0 || mem_wdata_o !== 32'h0 || d_rdata_o !== 32'h0 || if_rdata_o !== 32'h0)
            $display("FAIL rstmid_outs got req=%b we=%b dack=%b iack=%b err=%b be=%h addr=%h wdata=%h drd=%h ird=%h want all 0",
                     mem_req_o, mem_we_o, d_ack_o, if_ack_o, err_o, mem_be_o, mem_addr_o, mem_wdata_o,
                     d_rdata_o, if_rdata_o);
        else passed++;
        next_cycle();
        @(negedge clk_i);
        total++;
        if (mem_req_o !== 1'b0 || d_ack_o !== 1'b0)
            $display("FAIL rstmid_idle got req=%b dack=%b want 0 0", mem_req_o, d_ack_o);
        else passed++;
    endtask

    task automatic test_spurious();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            if (c > 0) next_cycle();
            mem_ack_i = 1; mem_rdata_i = $urandom;
            @(negedge clk_i);
            total++;
            if (if_ack_o !== 1'b0 || d_ack_o !== 1'b0 || mem_req_o !== 1'b0 ||
                if_rdata_o !== 32'h0 || d_rdata_o !== 32'h0)
                $display("FAIL spurious_c%0d got iack=%b dack=%b req=%b ird=%h drd=%h want 0 0 0 0 0",
                         c, if_ack_o, d_ack_o, mem_req_o, if_rdata_o, d_rdata_o);
            else passed++;
        end
        next_cycle();
        mem_ack_i = 0; if_req_i = 1; if_addr_i = 32'h0000_0ABC;
        @(negedge clk_i);
        next_cycle();
        @(negedge clk_i);
        total++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0000_0ABC || if_ack_o !== 1'b0)
            $display("FAIL spurious_after got req=%b addr=%h iack=%b want 1 abc 0", mem_req_o, mem_addr_o, if_ack_o);
        else passed++;
        next_cycle();
        mem_ack_i = 1; mem_rdata_i = 32'h0;
        @(negedge clk_i);
        next_cycle();
        mem_ack_i = 0; if_req_i = 0;
        @(negedge clk_i);
    endtask

    // Model: data (if any) is granted at cycle 1 and finishes at 1+min(wait,TO);
    // a fetch behind it is granted two cycles after that ack (one IDLE cycle between).
    task automatic test_random();
        bit err_m = 0;
        logic [31:0] last_i = 0;
        do_reset();
        for (int it = 0; it < 30; it++) begin
            int kind = $urandom_range(0, 2);
            bit has_i = (kind != 1);
            bit has_d = (kind != 0);
            bit st = 1'($urandom_range(0, 1));
            logic [31:0] ia = $urandom;
            logic [31:0] da = $urandom;
            logic [31:0] wd = $urandom;
            logic [3:0]  be = 4'($urandom);
            int wi = $urandom_range(0, 9);
            int wdw = $urandom_range(0, 9);
            logic [31:0] ri = $urandom;
            logic [31:0] rd = $urandom;
            int d_ack_c = has_d ? 1 + ((wdw < TO) ? wdw : TO) : -10;
            int d_end = (wdw < TO) ? 1 + wdw : TO;
            int i_start = has_d ? d_ack_c + 2 : 1;
            int i_ack_c = has_i ? i_start + ((wi < TO) ? wi : TO) : -10;
            int i_end = (wi < TO) ? i_start + wi : i_start + TO - 1;
            int end_c = (i_ack_c > d_ack_c) ? i_ack_c : d_ack_c;
            for (int c = 0; c <= end_c + 1; c++) begin
                bit in_d = has_d && c >= 1 && c <= d_end;
                bit in_i = has_i && c >= i_start && c <= i_end;
                bit e_iack = has_i && c == i_ack_c;
                bit e_dack = has_d && c == d_ack_c;
                logic [31:0] e_ird = e_iack ? ((wi < TO) ? ri : NOP) : last_i;
                if (it > 0 || c > 0) next_cycle();
                if_req_i = has_i && c <= i_ack_c; if_addr_i = ia;
                d_req_i = has_d && c <= d_ack_c; d_we_i = st; d_addr_i = da;
                d_wdata_i = wd; d_be_i = be;
                if (e_dack && wdw < TO) begin
                    mem_ack_i = 1; mem_rdata_i = rd;
                end else if (e_iack && wi < TO) begin
                    mem_ack_i = 1; mem_rdata_i = ri;
                end else if (!(in_d || in_i)) begin
                    mem_ack_i = ($urandom_range(0, 3) == 0); mem_rdata_i = $urandom;
                end else begin
                    mem_ack_i = 0; mem_rdata_i = $urandom;
                end
                @(negedge clk_i);
                total++;
                if (if_ack_o !== e_iack || d_ack_o !== e_dack)
                    $display("FAIL rnd_ack it=%0d c=%0d got iack=%b dack=%b want %b %b",
                             it, c, if_ack_o, d_ack_o, e_iack, e_dack);
                else passed++;
                total++;
                if (stall_o !== ((if_req_i && !e_iack) || (d_req_i && !e_dack)))
                    $display("FAIL rnd_stall it=%0d c=%0d got %b want %b", it, c, stall_o,
                             (if_req_i && !e_iack) || (d_req_i && !e_dack));
                else passed++;
                total++;
                if (mem_req_o !== (in_d || in_i))
                    $display("FAIL rnd_memreq it=%0d c=%0d got %b want %b", it, c, mem_req_o, in_d || in_i);
                else passed++;
                total++;
                if (if_rdata_o !== e_ird)
                    $display("FAIL rnd_irdata it=%0d c=%0d got %h want %h", it, c, if_rdata_o, e_ird);
                else passed++;
                if (e_dack && (!st || wdw >= TO)) begin
                    total++;
                    if (d_rdata_o !== ((wdw < TO) ? rd : 32'h0))
                        $display("FAIL rnd_drdata it=%0d c=%0d got %h want %h", it, c, d_rdata_o,
                                 (wdw < TO) ? rd : 32'h0);
                    else passed++;
                end
                if (in_d) begin
                    total++;
                    if (mem_addr_o !== da || mem_we_o !== st || mem_be_o !== (st ? be : 4'h0) ||
                        (st && mem_wdata_o !== wd))
                        $display("FAIL rnd_dmem it=%0d c=%0d got addr=%h we=%b be=%h wdata=%h want %h %b %h %h",
                                 it, c, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o, da, st,
                                 st ? be : 4'h0, wd);
                    else passed++;
                end
                if (in_i) begin
                    total++;
                    if (mem_addr_o !== ia || mem_we_o !== 1'b0 || mem_be_o !== 4'h0)
                        $display("FAIL rnd_imem it=%0d c=%0d got addr=%h we=%b be=%h want %h 0 0",
                                 it, c, mem_addr_o, mem_we_o, mem_be_o, ia);
                    else passed++;
                end
                if (e_iack) last_i = e_ird;
            end
            if ((has_d && wdw >= TO) || (has_i && wi >= TO)) err_m = 1;
            total++;
            if (err_o !== err_m) $display("FAIL rnd_err it=%0d got %b want %b", it, err_o, err_m);
            else passed++;
        end
        next_cycle();
        inputs_idle();
    endtask

    initial begin
        inputs_idle();
        reset_i = 0;
        test_reset();
        test_fetch();
        test_priority();
        test_load_wait();
        test_timeout();
        test_reset_mid();
        test_spurious();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
